// File: rtl/bcd_pkg.sv
// Shared BCD types and digit-level helpers for the sequenced multiplier.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        MULT,
        DONE
    } state_t;

    typedef struct packed {
        logic               carry;
        logic [DIGIT_W-1:0] digit;
    } bcd_sum_t;

    function automatic logic bcd_digit_ok(input logic [DIGIT_W-1:0] d);
        return d <= 4'd9;
    endfunction

    // Inputs are valid digits, so the raw sum never exceeds 19 and one +6 fixes it.
    function automatic bcd_sum_t bcd_add_digit(input logic [DIGIT_W-1:0] x,
                                               input logic [DIGIT_W-1:0] y,
                                               input logic               cin);
        logic [4:0] s;
        bcd_sum_t   r;
        s = {1'b0, x} + {1'b0, y} + {4'b0, cin};
        if (s > 5'd9) begin
            s       = s + 5'd6;
            r.carry = 1'b1;
        end else begin
            r.carry = 1'b0;
        end
        r.digit = s[3:0];
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_mult.sv
// One BCD digit times one BCD digit, combinational; result is two BCD digits.
// Operands are validated upstream, so values above 9 are never presented.
module bcd_digit_mult
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0]   x_i,
    input  logic [DIGIT_W-1:0]   y_i,
    output logic [2*DIGIT_W-1:0] p_o
);

    logic [6:0]         prod;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;

    always_comb begin
        prod = {3'b0, x_i} * {3'b0, y_i};
        tens = 4'(prod / 7'd10);
        ones = 4'(prod % 7'd10);
        p_o  = {tens, ones};
    end

endmodule

// File: rtl/bcd_mult_sequencer.sv
// Multi-digit BCD multiplier: one digit pair per clock through a shared digit
// multiplier, partial products rippled into a BCD accumulator at offset i+j.
module bcd_mult_sequencer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [8*DIGITS-1:0]     res,
    output logic                    err,
    output logic                    busy
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t                  state_q;
    logic [4*DIGITS-1:0]     a_q;
    logic [4*DIGITS-1:0]     b_q;
    logic [IDX_W-1:0]        i_q;
    logic [IDX_W-1:0]        j_q;
    logic [8*DIGITS-1:0]     acc_q;
    logic [8*DIGITS-1:0]     acc_d;
    logic [8*DIGITS-1:0]     res_q;
    logic                    err_q;
    logic                    res_vld_q;

    logic [DIGIT_W-1:0]      a_dig;
    logic [DIGIT_W-1:0]      b_dig;
    logic [2*DIGIT_W-1:0]    pp;
    logic [8*DIGITS-1:0]     addend;
    logic                    ops_ok;
    logic                    last_pair;

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign res_valid   = res_vld_q;
    assign res         = res_q;
    assign err         = err_q;

    assign a_dig     = a_q[int'(i_q)*DIGIT_W +: DIGIT_W];
    assign b_dig     = b_q[int'(j_q)*DIGIT_W +: DIGIT_W];
    assign last_pair = (i_q == LAST_IDX) && (j_q == LAST_IDX);

    bcd_digit_mult u_digit_mult (
        .x_i (a_dig),
        .y_i (b_dig),
        .p_o (pp)
    );

    always_comb begin
        ops_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!bcd_digit_ok(a_q[k*DIGIT_W +: DIGIT_W]) ||
                !bcd_digit_ok(b_q[k*DIGIT_W +: DIGIT_W])) begin
                ops_ok = 1'b0;
            end
        end
    end

    // A carry out of the top digit is impossible for a DIGITSxDIGITS product and is dropped.
    always_comb begin
        int       off;
        logic     carry;
        bcd_sum_t s;
        addend = '0;
        off    = int'(i_q) + int'(j_q);
        addend[off*DIGIT_W +: DIGIT_W]     = pp[3:0];
        addend[(off+1)*DIGIT_W +: DIGIT_W] = pp[7:4];
        acc_d  = '0;
        carry  = 1'b0;
        for (int k = 0; k < 2*DIGITS; k++) begin
            s = bcd_add_digit(acc_q[k*DIGIT_W +: DIGIT_W], addend[k*DIGIT_W +: DIGIT_W], carry);
            acc_d[k*DIGIT_W +: DIGIT_W] = s.digit;
            carry = s.carry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            res_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (!ops_ok) begin
                        res_q     <= {2*DIGITS{BCD_INVALID}};
                        err_q     <= 1'b1;
                        res_vld_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        err_q   <= 1'b0;
                        state_q <= MULT;
                    end
                end
                MULT: begin
                    acc_q <= acc_d;
                    if (last_pair) begin
                        res_q     <= acc_d;
                        res_vld_q <= 1'b1;
                        state_q   <= DONE;
                    end else if (i_q == LAST_IDX) begin
                        i_q <= '0;
                        j_q <= j_q + IDX_W'(1);
                    end else begin
                        i_q <= i_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_mult_sequencer.sv
// Directed bench for bcd_mult_sequencer with DIGITS=2.
module tb_bcd_mult_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res;
    logic        err;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    bcd_mult_sequencer #(.DIGITS(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res         (res),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands, waits (bounded) for start_ready, leaves us 1ns after the accept edge.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, output bit ok);
        int n = 0;
        a = av;
        b = bv;
        start_valid = 1'b1;
        while (!start_ready && n < 20) begin
            tick();
            n++;
        end
        ok = start_ready;
        tick();
        start_valid = 1'b0;
    endtask

    task automatic wait_res(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 30) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_valid = 1'b0;
        res_ready = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        tests_run++; if (start_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_start_ready got %b want 1", start_ready); end
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        tests_run++; if (res !== 16'h0000) begin tests_failed++; $display("FAIL reset_res got %h want 0000", res); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", err); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int cyc;
        res_ready = 1'b1;
        start_op(8'h12, 8'h34, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL basic_accept start_ready never rose"); end
        wait_res(cyc);
        tests_run++; if (cyc != 5) begin tests_failed++; $display("FAIL basic_latency got %0d want 5", cyc); end
        tests_run++; if (res !== 16'h0408) begin tests_failed++; $display("FAIL basic_res got %h want 0408", res); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL basic_err got %b want 0", err); end
        tick();
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_one_cycle got %b want 0", res_valid); end
        tests_run++; if (start_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_idle_ready got %b want 1", start_ready); end
        tests_run++; if (res !== 16'h0408) begin tests_failed++; $display("FAIL basic_res_hold got %h want 0408", res); end
    endtask

    task automatic test_carry();
        bit ok;
        int cyc;
        res_ready = 1'b1;
        start_op(8'h99, 8'h99, ok);
        wait_res(cyc);
        tests_run++; if (cyc != 5) begin tests_failed++; $display("FAIL carry_latency got %0d want 5", cyc); end
        tests_run++; if (res !== 16'h9801) begin tests_failed++; $display("FAIL carry_res got %h want 9801", res); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL carry_err got %b want 0", err); end
        tick();
    endtask

    task automatic test_invalid();
        bit ok;
        int cyc;
        logic [7:0] av [2] = '{8'h1A, 8'h05};
        logic [7:0] bv [2] = '{8'h05, 8'hF0};
        res_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            start_op(av[t], bv[t], ok);
            wait_res(cyc);
            tests_run++; if (cyc != 1) begin tests_failed++; $display("FAIL invalid%0d_latency got %0d want 1", t, cyc); end
            tests_run++; if (res !== 16'hFFFF) begin tests_failed++; $display("FAIL invalid%0d_res got %h want ffff", t, res); end
            tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL invalid%0d_err got %b want 1", t, err); end
            tick();
        end
    endtask

    task automatic test_stall();
        bit ok;
        int cyc;
        res_ready = 1'b0;
        start_op(8'h07, 8'h08, ok);
        a = 8'h99;
        b = 8'h99;
        wait_res(cyc);
        tests_run++; if (cyc != 5) begin tests_failed++; $display("FAIL stall_latency got %0d want 5", cyc); end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (res !== 16'h0056 || res_valid !== 1'b1 || err !== 1'b0 || start_ready !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold cyc %0d got res=%h vld=%b err=%b rdy=%b busy=%b want 0056 1 0 0 1",
                         k, res, res_valid, err, start_ready, busy);
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        tests_run++; if (start_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_release_ready got %b want 1", start_ready); end
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_release_valid got %b want 0", res_valid); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        res_ready = 1'b1;
        start_op(8'h12, 8'h34, ok);
        tick();
        tick();
        a = 8'h11;
        b = 8'h11;
        start_valid = 1'b1;
        reset = 1'b1;
        #1;
        tests_run++; if (res !== 16'h0000) begin tests_failed++; $display("FAIL midrst_res got %h want 0000", res); end
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid got %b want 0", res_valid); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL midrst_err got %b want 0", err); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got %b want 0", busy); end
        tick();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_start_ignored busy got %b want 0", busy); end
        start_valid = 1'b0;
        reset = 1'b0;
        tick();
        start_op(8'h25, 8'h04, ok);
        wait_res(cyc);
        tests_run++; if (cyc != 5) begin tests_failed++; $display("FAIL midrst_next_latency got %0d want 5", cyc); end
        tests_run++; if (res !== 16'h0100) begin tests_failed++; $display("FAIL midrst_next_res got %h want 0100", res); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        res_ready = 1'b1;
        a = 8'h00;
        b = 8'h57;
        start_valid = 1'b1;
        tests_run++; if (start_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_idle_ready got %b want 1", start_ready); end
        tick();
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_accept busy got %b want 1", busy); end
        a = 8'h50;
        b = 8'h20;
        wait_res(cyc);
        tests_run++; if (cyc != 5) begin tests_failed++; $display("FAIL b2b_first_latency got %0d want 5", cyc); end
        tests_run++; if (res !== 16'h0000) begin tests_failed++; $display("FAIL b2b_first_res got %h want 0000", res); end
        tick();
        tests_run++; if (start_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_after_handshake got rdy=%b busy=%b want 1 0", start_ready, busy);
        end
        tick();
        tests_run++; if (busy !== 1'b1 || start_ready !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_second_accept got busy=%b rdy=%b want 1 0", busy, start_ready);
        end
        start_valid = 1'b0;
        wait_res(cyc);
        tests_run++; if (cyc != 5) begin tests_failed++; $display("FAIL b2b_second_latency got %0d want 5", cyc); end
        tests_run++; if (res !== 16'h1000) begin tests_failed++; $display("FAIL b2b_second_res got %h want 1000", res); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL b2b_second_err got %b want 0", err); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_invalid();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
